// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: state encoding,
// default geometry and the owner-to-one-hot helper.
package mult_arb_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned TIMEOUT_DEF = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals around the arbiter.
// slave = arbiter view, master = requesters plus multiplier view.
interface mult_arbiter_if import mult_arb_pkg::*; #(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       resp_valid;
    logic [WIDTH-1:0] resp_result;
    logic             resp_exception;
    logic [WIDTH-1:0] m_operandA;
    logic [WIDTH-1:0] m_operandB;
    logic             m_ctrl_MULT;
    logic [WIDTH-1:0] m_result;
    logic             m_exception;
    logic             m_resultRDY;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1,
        input  m_result, m_exception, m_resultRDY,
        output req_ready, resp_valid, resp_result, resp_exception,
        output m_operandA, m_operandB, m_ctrl_MULT
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1,
        output m_result, m_exception, m_resultRDY,
        input  req_ready, resp_valid, resp_result, resp_exception,
        input  m_operandA, m_operandB, m_ctrl_MULT
    );
endinterface

// File: rtl/mult_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the
// requester named by rr_i. Purely combinational.
module rr_pick2 (
    input  logic [1:0] req_valid_i,
    input  logic       rr_i,
    output logic [1:0] grant_o,
    output logic       idx_o
);

    // Grant selection from the request pattern and the tie-break pointer
    always_comb begin
        grant_o = 2'b00;
        idx_o   = 1'b0;
        case (req_valid_i)
            2'b01: begin
                grant_o = 2'b01;
                idx_o   = 1'b0;
            end
            2'b10: begin
                grant_o = 2'b10;
                idx_o   = 1'b1;
            end
            2'b11: begin
                grant_o = rr_i ? 2'b10 : 2'b01;
                idx_o   = rr_i;
            end
            default: begin
                grant_o = 2'b00;
                idx_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one iterative multiplier between two requesters: round-robin accept,
// one-cycle start pulse, watchdog-guarded wait, one-cycle response to the owner.
module mult_arbiter import mult_arb_pkg::*; #(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clock,
    input  logic            reset,
    mult_arbiter_if.slave   bus
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_e       state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic             start_q, start_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [1:0]       grant_s;
    logic             win_s;

    rr_pick2 u_pick (
        .req_valid_i (bus.req_valid),
        .rr_i        (rr_q),
        .grant_o     (grant_s),
        .idx_o       (win_s)
    );

    assign bus.req_ready      = (state_q == ST_IDLE) ? grant_s : 2'b00;
    assign bus.resp_valid     = rvalid_q;
    assign bus.resp_result    = res_q;
    assign bus.resp_exception = exc_q;
    assign bus.m_operandA     = opa_q;
    assign bus.m_operandB     = opb_q;
    assign bus.m_ctrl_MULT    = start_q;

    // Next-state and datapath loads; RDY is only honoured while BUSY
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    owner_d = win_s;
                    opa_d   = win_s ? bus.req_a1 : bus.req_a0;
                    opb_d   = win_s ? bus.req_b1 : bus.req_b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                // A result arriving on the watchdog's last cycle still counts
                if (bus.m_resultRDY) begin
                    res_d   = bus.m_result;
                    exc_d   = bus.m_exception;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    res_d   = {WIDTH{1'b0}};
                    exc_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                rr_d    = ~owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        start_d  = (state_d == ST_START);
        rvalid_d = (state_d == ST_DONE) ? owner_onehot(owner_d) : 2'b00;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b0;
            owner_q  <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            opa_q    <= {WIDTH{1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            exc_q    <= 1'b0;
            start_q  <= 1'b0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            start_q  <= start_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one iterative 32-bit multiplier between two requesters (e.g. two pipeline issue slots, or pipeline and debug port). The arbiter accepts an operand pair, holds the operands stable on the multiplier inputs, issues the one-cycle start pulse, waits for result-ready under a watchdog, and returns the result and exception flag to the requester that owns the operation. Grants are round-robin. One operation is in flight at a time.

## Interface
- `WIDTH`, 32: operand/result width.
- `TIMEOUT`, 40: maximum BUSY cycles before the watchdog aborts the operation.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  2  per-requester request; bit i = requester i.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  WIDTH  operands per requester.
- `req_ready`  out  2  accept strobe; a transfer occurs when valid and ready are both 1.
- `resp_valid`  out  2  one-cycle response pulse to the owner.
- `resp_result`  out  WIDTH  product low word; shared bus, qualified by `resp_valid`.
- `resp_exception`  out  1  overflow from multiplier, or watchdog abort; qualified by `resp_valid`.
- `m_operandA`, `m_operandB`  out  WIDTH  multiplier operands; registered.
- `m_ctrl_MULT`  out  1  multiplier start pulse.
- `m_result`  in  WIDTH  multiplier result.
- `m_exception`  in  1  multiplier overflow.
- `m_resultRDY`  in  1  multiplier done.

## Operation
- States: IDLE, START, BUSY, DONE.
- IDLE: `req_ready` is driven combinationally. If exactly one `req_valid` bit is set, that requester gets ready. If both are set, the round-robin pointer `rr` chooses the requester. The chosen requester's operands go into `m_operandA`/`m_operandB`, its index goes into `owner`, and the state moves to START. With no valid request, the arbiter stays in IDLE.
- START: `m_ctrl_MULT` = 1 for exactly this cycle. The BUSY counter clears. The state moves to BUSY.
- BUSY: the counter increments each cycle.
  - If `m_resultRDY` = 1: register `m_result` and `m_exception`, then go to DONE.
  - If the counter reaches `TIMEOUT` without `m_resultRDY`: register result 0 and exception 1, then go to DONE.
  - If both conditions occur in the same cycle, `m_resultRDY` wins.
- DONE: `resp_valid[owner]` = 1 with the registered result and exception. `rr` is set to `~owner`. The state moves to IDLE.
- `m_resultRDY` is ignored in IDLE, START and DONE, because the multiplier's free-running counter can raise it spuriously.
- `m_operandA`/`m_operandB` hold their value from START through DONE and are unchanged in IDLE. The multiplier reads them combinationally every cycle.
- `req_ready` is 0 in every state except IDLE. Requesters hold valid and operands until accepted.
- There is no response backpressure. The owner samples `resp_valid` in that cycle.

## Timing
- Reset values: state IDLE, `rr`=0, `owner`=0, counter 0. Outputs: `req_ready` as IDLE logic dictates, `resp_valid`=0, `resp_result`=0, `resp_exception`=0, `m_operandA`/`m_operandB`=0, `m_ctrl_MULT`=0.
- Reset mid-operation: the arbiter aborts immediately. There is no response for the in-flight operation, and the requester must re-request.
- Cycle timeline, with the accept edge at cycle 0:
  - `m_ctrl_MULT` is high in cycle 1.
  - BUSY runs from cycle 2.
  - If `m_resultRDY` is first seen in BUSY cycle k (k≥0, cycle 2+k), `resp_valid` is high in cycle 3+k.
  - The earliest next accept is cycle 4+k.
- Watchdog abort: `resp_valid` is high in cycle 3+`TIMEOUT`.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- Counter width: $clog2(`TIMEOUT`+1). The counter saturates and never wraps.

## Structure
- Package `mult_arb_pkg` holds:
  - the state encoding (2-bit: IDLE=0, START=1, BUSY=2, DONE=3);
  - the default `WIDTH` and `TIMEOUT` constants.
- Sub-module `rr_pick2` is combinational. Inputs are `req_valid[1:0]` and `rr`. Outputs are a one-hot grant and the winner index. It is reused by other shared-resource arbiters.
- Everything else lives in the single `mult_arbiter` module: the FSM, the operand/result registers and the watchdog counter.

## Test plan
- Single request: requester 0, a=6, b=7. Expect accept at cycle 0, `m_ctrl_MULT` pulse in cycle 1, then `resp_valid`=01 with result 42 and exception 0, one cycle after RDY.
- Simultaneous requests after reset, requester 0 with (3,5) and requester 1 with (−4,9). Requester 0 is served first (result 15), then requester 1 (result −36, 0xFFFFFFDC). The next simultaneous pair goes to requester 0 again, because `rr` follows the last owner.
- Overflow: 0x40000000×4. Expect resp_exception=1, with the response routed to the correct owner.
- Spurious RDY: hold `m_resultRDY`=1 during IDLE and START. Expect no early transition, and `req_ready` stays 0 outside IDLE.
- Watchdog: the multiplier model never raises RDY. Expect `resp_valid` in cycle 3+`TIMEOUT` with result 0 and exception 1, followed by a return to IDLE.
- Reset in BUSY: assert `reset` asynchronously mid-operation. Expect all outputs to return to their reset values at once with no response. A fresh request afterward completes normally.
